// File: rtl/multi_debounce.sv
// Multi-channel push-button conditioner: per-channel synchroniser, stability
// debouncer, press/release edge pulses, long-press timer and sticky press flag.
module multi_debounce #(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = 8,
  parameter int LONG_CNT   = 1000,
  parameter int CNT_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb_in,
  input  logic [N_CH-1:0] evt_clr,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] press,
  // 'release' is a reserved word in SystemVerilog, hence the suffix
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] evt_pending
);

  localparam logic             IDLE        = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] stab_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             pend_q;

    logic             flip;
    logic             nxt_level;
    logic             press_edge;
    logic             release_edge;

    // The debounced level flips only once sync2 has disagreed for STABLE_CNT edges.
    always_comb begin
      flip         = 1'b0;
      nxt_level    = level_q;
      press_edge   = 1'b0;
      release_edge = 1'b0;
      if ((sync2_q != level_q) && (stab_cnt_q == STABLE_LAST)) begin
        flip         = 1'b1;
        nxt_level    = sync2_q;
        press_edge   = (sync2_q != IDLE);
        release_edge = (sync2_q == IDLE);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q    <= IDLE;
        sync2_q    <= IDLE;
        level_q    <= IDLE;
        stab_cnt_q <= '0;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        pend_q     <= 1'b0;
      end else begin
        sync1_q <= pb_in[i];
        sync2_q <= sync1_q;

        if (sync2_q == level_q || flip) begin
          stab_cnt_q <= '0;
        end else begin
          stab_cnt_q <= stab_cnt_q + 1'b1;
        end

        level_q   <= nxt_level;
        press_q   <= press_edge;
        release_q <= release_edge;

        // Hold timer follows the next level so a release on the terminal edge wins.
        if (press_edge || nxt_level == IDLE) begin
          hold_cnt_q <= '0;
          long_q     <= 1'b0;
        end else if (hold_cnt_q < LONG_MAX) begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          long_q     <= (hold_cnt_q == LONG_LAST);
        end else begin
          long_q <= 1'b0;
        end

        if (press_edge) begin
          pend_q <= 1'b1;
        end else if (evt_clr[i]) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign pb_level[i]      = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
    assign long_press[i]    = long_q;
    assign evt_pending[i]   = pend_q;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: 4 active-low channels, STABLE_CNT=4, LONG_CNT=10.
module tb_multi_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb_in;
  logic [3:0] evt_clr;
  logic [3:0] pb_level;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic [3:0] long_press;
  logic [3:0] evt_pending;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_debounce #(
    .N_CH(4), .STABLE_CNT(4), .LONG_CNT(10), .CNT_W(16), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .pb_in(pb_in), .evt_clr(evt_clr),
    .pb_level(pb_level), .press(press), .release_pulse(release_pulse),
    .long_press(long_press), .evt_pending(evt_pending)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pb_in = 4'hF; evt_clr = 4'h0;
    repeat (3) tick();
    tests_run++;
    if ({pb_level, press, release_pulse, long_press, evt_pending} !== {4'hF, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_hold got=%h exp=%h",
               {pb_level, press, release_pulse, long_press, evt_pending}, {4'hF, 16'h0});
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      tests_run++;
      if ({pb_level, press, release_pulse, long_press, evt_pending} !== {4'hF, 16'h0}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i,
                 {pb_level, press, release_pulse, long_press, evt_pending}, {4'hF, 16'h0});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_lvl, exp_prs, exp_rel;
    pb_in[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_lvl = (i >= 6) ? 4'hE : 4'hF;
      exp_prs = (i == 6) ? 4'h1 : 4'h0;
      tests_run++;
      if (pb_level !== exp_lvl || press !== exp_prs || evt_pending !== ((i >= 6) ? 4'h1 : 4'h0)
          || release_pulse !== 4'h0 || long_press !== 4'h0) begin
        tests_failed++;
        $display("FAIL clean_press cyc=%0d lvl=%h prs=%h pend=%h rel=%h lng=%h exp_lvl=%h exp_prs=%h",
                 i, pb_level, press, evt_pending, release_pulse, long_press, exp_lvl, exp_prs);
      end
    end
    pb_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_lvl = (i >= 6) ? 4'hF : 4'hE;
      exp_rel = (i == 6) ? 4'h1 : 4'h0;
      tests_run++;
      if (pb_level !== exp_lvl || release_pulse !== exp_rel || press !== 4'h0
          || long_press !== 4'h0 || evt_pending !== 4'h1) begin
        tests_failed++;
        $display("FAIL clean_release cyc=%0d lvl=%h rel=%h prs=%h lng=%h pend=%h exp_lvl=%h exp_rel=%h",
                 i, pb_level, release_pulse, press, long_press, evt_pending, exp_lvl, exp_rel);
      end
    end
    evt_clr = 4'h1;
    tick();
    evt_clr = 4'h0;
    tests_run++;
    if (evt_pending !== 4'h0) begin
      tests_failed++;
      $display("FAIL evt_clear got=%h exp=%h", evt_pending, 4'h0);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_lvl, exp_prs, exp_rel, exp_lng;
    for (int t = 0; t <= 26; t++) begin
      pb_in[1] = (t < 3) ? 1'b0 : (t < 5) ? 1'b1 : (t < 16) ? 1'b0 : 1'b1;
      tick();
      exp_lvl = (t >= 10 && t <= 20) ? 4'hD : 4'hF;
      exp_prs = (t == 10) ? 4'h2 : 4'h0;
      exp_lng = (t == 20) ? 4'h2 : 4'h0;
      exp_rel = (t == 21) ? 4'h2 : 4'h0;
      tests_run++;
      if (pb_level !== exp_lvl || press !== exp_prs || long_press !== exp_lng
          || release_pulse !== exp_rel) begin
        tests_failed++;
        $display("FAIL bounce t=%0d lvl=%h prs=%h lng=%h rel=%h exp=%h/%h/%h/%h",
                 t, pb_level, press, long_press, release_pulse, exp_lvl, exp_prs, exp_lng, exp_rel);
      end
    end
  endtask

  task automatic test_long_press();
    logic [3:0] exp_lvl, exp_prs, exp_rel, exp_lng;
    for (int t = 0; t <= 40; t++) begin
      pb_in[2] = (t < 30) ? 1'b0 : 1'b1;
      tick();
      exp_lvl = (t >= 5 && t <= 34) ? 4'hB : 4'hF;
      exp_prs = (t == 5)  ? 4'h4 : 4'h0;
      exp_lng = (t == 15) ? 4'h4 : 4'h0;
      exp_rel = (t == 35) ? 4'h4 : 4'h0;
      tests_run++;
      if (pb_level !== exp_lvl || press !== exp_prs || long_press !== exp_lng
          || release_pulse !== exp_rel) begin
        tests_failed++;
        $display("FAIL long_press t=%0d lvl=%h prs=%h lng=%h rel=%h exp=%h/%h/%h/%h",
                 t, pb_level, press, long_press, release_pulse, exp_lvl, exp_prs, exp_lng, exp_rel);
      end
    end
    for (int t = 0; t <= 20; t++) begin
      pb_in[2] = (t < 6) ? 1'b0 : 1'b1;
      tick();
      exp_lvl = (t >= 5 && t <= 10) ? 4'hB : 4'hF;
      exp_prs = (t == 5)  ? 4'h4 : 4'h0;
      exp_rel = (t == 11) ? 4'h4 : 4'h0;
      tests_run++;
      if (pb_level !== exp_lvl || press !== exp_prs || long_press !== 4'h0
          || release_pulse !== exp_rel) begin
        tests_failed++;
        $display("FAIL short_press t=%0d lvl=%h prs=%h lng=%h rel=%h exp=%h/%h/0/%h",
                 t, pb_level, press, long_press, release_pulse, exp_lvl, exp_prs, exp_rel);
      end
    end
  endtask

  task automatic test_toggle();
    for (int t = 0; t <= 25; t++) begin
      pb_in[3] = (t < 20) ? t[0] : 1'b1;
      tick();
      tests_run++;
      if (pb_level !== 4'hF || press !== 4'h0 || release_pulse !== 4'h0) begin
        tests_failed++;
        $display("FAIL toggle t=%0d lvl=%h prs=%h rel=%h exp=f/0/0",
                 t, pb_level, press, release_pulse);
      end
    end
  endtask

  task automatic test_collision();
    logic exp_pend, exp_prs, exp_rel;
    for (int t = 0; t <= 14; t++) begin
      pb_in[0]   = (t < 7) ? 1'b0 : 1'b1;
      evt_clr[0] = (t == 5 || t == 6);
      tick();
      exp_pend = (t == 5);
      exp_prs  = (t == 5);
      exp_rel  = (t == 12);
      tests_run++;
      if (evt_pending[0] !== exp_pend || press[0] !== exp_prs || release_pulse[0] !== exp_rel) begin
        tests_failed++;
        $display("FAIL collision t=%0d pend=%b prs=%b rel=%b exp=%b/%b/%b",
                 t, evt_pending[0], press[0], release_pulse[0], exp_pend, exp_prs, exp_rel);
      end
    end
    evt_clr = 4'h0;
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t <= 10; t++) begin
      pb_in[0] = 1'b0;
      pb_in[3] = (t >= 7) ? 1'b0 : 1'b1;
      tick();
    end
    tests_run++;
    if (pb_level[0] !== 1'b0 || evt_pending[0] !== 1'b1 || pb_level[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset lvl=%h pend=%h exp lvl[0]=0 lvl[3]=1 pend[0]=1", pb_level, evt_pending);
    end
    rst = 1'b1;
    pb_in = 4'hF;
    #1;
    tests_run++;
    if ({pb_level, press, release_pulse, long_press, evt_pending} !== {4'hF, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_async got=%h exp=%h",
               {pb_level, press, release_pulse, long_press, evt_pending}, {4'hF, 16'h0});
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      tests_run++;
      if ({pb_level, press, release_pulse, long_press, evt_pending} !== {4'hF, 16'h0}) begin
        tests_failed++;
        $display("FAIL reset_after cyc=%0d got=%h exp=%h", i,
                 {pb_level, press, release_pulse, long_press, evt_pending}, {4'hF, 16'h0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_toggle();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
